// File: rtl/rx_frame_buffer.sv
// rx_frame_buffer: store-and-forward receive buffer between the MAC Rx
// stream and the frame-to-DRAM stage. Each frame is held until its tlast
// beat. Good frames are committed and replayed with their byte count on
// out_m_tuser from the first beat. Bad, oversize or overflowing frames are
// rolled back and counted in drop_count.
//
// Stream handshake (both ports): a beat transfers on a rising edge where
// tvalid && tready are both high. A source holding tvalid keeps tdata, tkeep,
// tuser and tlast stable until that transfer. tready never depends on tvalid.
module rx_frame_buffer #(
  parameter int DATA_DWORDS     = 2048,
  parameter int LEN_DEPTH       = 16,
  parameter int MAX_FRAME_BYTES = 16383
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [31:0] mac_s_tdata,
  input  logic [3:0]  mac_s_tkeep,
  input  logic        mac_s_tuser,
  input  logic        mac_s_tvalid,
  input  logic        mac_s_tlast,
  output logic        mac_s_tready,
  output logic [31:0] out_m_tdata,
  output logic [3:0]  out_m_tkeep,
  output logic [15:0] out_m_tuser,
  output logic        out_m_tvalid,
  output logic        out_m_tlast,
  input  logic        out_m_tready,
  output logic [15:0] drop_count,
  output logic [1:0]  dbg_wr_state
);
  localparam int AW  = $clog2(DATA_DWORDS);
  localparam int PW  = AW + 1;
  localparam int LW  = $clog2(LEN_DEPTH);
  localparam int LPW = LW + 1;
  localparam logic [PW-1:0]  DEPTH_P     = PW'(DATA_DWORDS);
  localparam logic [LPW-1:0] LEN_DEPTH_P = LPW'(LEN_DEPTH);
  localparam logic [16:0]    MAX_B       = 17'(MAX_FRAME_BYTES);

  localparam logic [1:0] W_STORE   = 2'd0;
  localparam logic [1:0] W_DISCARD = 2'd1;
  localparam logic [1:0] R_IDLE    = 2'd0;
  localparam logic [1:0] R_HEAD    = 2'd1;
  localparam logic [1:0] R_SEND    = 2'd2;

  logic [1:0]     wr_state_q, wr_state_d;
  logic [PW-1:0]  wr_cur_q, wr_cur_d, wr_commit_q, wr_commit_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [16:0]    byte_cnt_q, byte_cnt_d, byte_sum;
  logic [2:0]     keep_cnt;
  logic [15:0]    drop_count_q;
  logic           drop_inc, mem_we, len_push, len_pop, frame_done, run_q;
  logic [PW-1:0]  space;
  logic           len_full, len_empty, len_avail_dly, in_progress, beat_acc;
  logic [LPW-1:0] len_wr_q, len_rd_q, len_wr_dly_q, inflight_q;
  logic [15:0]    len_mem [LEN_DEPTH];
  logic [15:0]    len_head, head_beats;
  logic [35:0]    mem [DATA_DWORDS];
  logic [35:0]    ram_rdata_q;
  logic [AW-1:0]  rd_addr;

  logic [1:0]  rd_state_q, rd_state_d;
  logic [15:0] beats_left_q, beats_left_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_keep_q, out_keep_d;
  logic [15:0] out_user_q, out_user_d;
  logic        out_valid_q, out_valid_d, out_last_q, out_last_d, handshake;

  assign space       = DEPTH_P - (wr_cur_q - rd_ptr_q);
  assign len_full    = (inflight_q == LEN_DEPTH_P);
  assign len_empty   = (len_wr_q == len_rd_q);
  // Chaining reads a word fetched one cycle earlier, so it only trusts
  // frames committed at least one cycle before that fetch.
  assign len_avail_dly = (len_wr_dly_q != len_rd_q);
  assign in_progress = (wr_cur_q != wr_commit_q);
  assign keep_cnt    = {2'b0, mac_s_tkeep[3]} + {2'b0, mac_s_tkeep[2]} +
                       {2'b0, mac_s_tkeep[1]} + {2'b0, mac_s_tkeep[0]};
  assign byte_sum    = byte_cnt_q + 17'(keep_cnt);
  assign len_head    = len_mem[len_rd_q[LW-1:0]];
  assign head_beats  = 16'((17'(len_head) + 17'd3) >> 2);

  assign mac_s_tready = run_q && ((wr_state_q == W_DISCARD) ||
                                  ((space != '0) && !len_full));
  assign beat_acc     = mac_s_tvalid && mac_s_tready;
  assign handshake    = out_valid_q && out_m_tready;

  assign out_m_tdata  = out_data_q;
  assign out_m_tkeep  = out_keep_q;
  assign out_m_tuser  = out_user_q;
  assign out_m_tvalid = out_valid_q;
  assign out_m_tlast  = out_last_q;
  assign drop_count   = drop_count_q;
  assign dbg_wr_state = wr_state_q;

  // Write FSM: store beats, commit good frames, roll back and drop the rest.
  always_comb begin
    wr_state_d  = wr_state_q;
    wr_cur_d    = wr_cur_q;
    wr_commit_d = wr_commit_q;
    byte_cnt_d  = byte_cnt_q;
    mem_we      = 1'b0;
    len_push    = 1'b0;
    drop_inc    = 1'b0;
    case (wr_state_q)
      W_STORE: begin
        if (mac_s_tvalid && (space == '0) && in_progress) begin
          wr_cur_d   = wr_commit_q;
          byte_cnt_d = '0;
          wr_state_d = W_DISCARD;
        end else if (beat_acc) begin
          mem_we   = 1'b1;
          wr_cur_d = wr_cur_q + PW'(1);
          if (mac_s_tlast) begin
            byte_cnt_d = '0;
            if (mac_s_tuser || (byte_sum == '0) || (byte_sum > MAX_B)) begin
              wr_cur_d = wr_commit_q;
              drop_inc = 1'b1;
            end else begin
              wr_commit_d = wr_cur_q + PW'(1);
              len_push    = 1'b1;
            end
          end else if (byte_sum > MAX_B) begin
            wr_cur_d   = wr_commit_q;
            byte_cnt_d = '0;
            wr_state_d = W_DISCARD;
          end else begin
            byte_cnt_d = byte_sum;
          end
        end
      end
      W_DISCARD: begin
        if (beat_acc && mac_s_tlast) begin
          drop_inc   = 1'b1;
          wr_state_d = W_STORE;
        end
      end
      default: wr_state_d = W_STORE;
    endcase
  end

  // Read FSM: the RAM output register always holds the word after the one
  // on the output, which together form the 2-entry skid for 1 beat/cycle.
  always_comb begin
    rd_state_d   = rd_state_q;
    rd_ptr_d     = rd_ptr_q;
    beats_left_d = beats_left_q;
    out_data_d   = out_data_q;
    out_keep_d   = out_keep_q;
    out_user_d   = out_user_q;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    len_pop      = 1'b0;
    frame_done   = 1'b0;
    rd_addr      = rd_ptr_q[AW-1:0] + AW'(1);
    case (rd_state_q)
      R_IDLE: begin
        rd_addr = rd_ptr_q[AW-1:0];
        if (!len_empty) begin
          len_pop      = 1'b1;
          beats_left_d = head_beats;
          out_user_d   = len_head;
          rd_state_d   = R_HEAD;
        end
      end
      R_HEAD: begin
        out_data_d  = ram_rdata_q[31:0];
        out_keep_d  = ram_rdata_q[35:32];
        out_valid_d = 1'b1;
        out_last_d  = (beats_left_q == 16'd1);
        rd_state_d  = R_SEND;
      end
      R_SEND: begin
        if (handshake) begin
          rd_ptr_d = rd_ptr_q + PW'(1);
          rd_addr  = rd_ptr_q[AW-1:0] + AW'(2);
          if (out_last_q) begin
            frame_done = 1'b1;
            if (len_avail_dly) begin
              len_pop      = 1'b1;
              beats_left_d = head_beats;
              out_user_d   = len_head;
              out_data_d   = ram_rdata_q[31:0];
              out_keep_d   = ram_rdata_q[35:32];
              out_last_d   = (head_beats == 16'd1);
            end else begin
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
              rd_state_d  = R_IDLE;
            end
          end else begin
            beats_left_d = beats_left_q - 16'd1;
            out_data_d   = ram_rdata_q[31:0];
            out_keep_d   = ram_rdata_q[35:32];
            out_last_d   = (beats_left_q == 16'd2);
          end
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Data RAM and frame length storage (no reset; pointers define content).
  always_ff @(posedge aclk) begin
    if (mem_we) mem[wr_cur_q[AW-1:0]] <= {mac_s_tkeep, mac_s_tdata};
    ram_rdata_q <= mem[rd_addr];
    if (len_push) len_mem[len_wr_q[LW-1:0]] <= byte_sum[15:0];
  end

  // State, pointers and counters; reset discards every stored frame.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      run_q        <= 1'b0;
      wr_state_q   <= W_STORE;
      wr_cur_q     <= '0;
      wr_commit_q  <= '0;
      rd_ptr_q     <= '0;
      byte_cnt_q   <= '0;
      drop_count_q <= '0;
      len_wr_q     <= '0;
      len_wr_dly_q <= '0;
      len_rd_q     <= '0;
      inflight_q   <= '0;
      rd_state_q   <= R_IDLE;
      beats_left_q <= '0;
      out_data_q   <= '0;
      out_keep_q   <= '0;
      out_user_q   <= '0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
    end else begin
      run_q        <= 1'b1;
      wr_state_q   <= wr_state_d;
      wr_cur_q     <= wr_cur_d;
      wr_commit_q  <= wr_commit_d;
      rd_ptr_q     <= rd_ptr_d;
      byte_cnt_q   <= byte_cnt_d;
      if (drop_inc && (drop_count_q != 16'hFFFF)) drop_count_q <= drop_count_q + 16'd1;
      if (len_push) len_wr_q <= len_wr_q + LPW'(1);
      len_wr_dly_q <= len_wr_q;
      if (len_pop) len_rd_q <= len_rd_q + LPW'(1);
      case ({len_push, frame_done})
        2'b10:   inflight_q <= inflight_q + LPW'(1);
        2'b01:   inflight_q <= inflight_q - LPW'(1);
        default: inflight_q <= inflight_q;
      endcase
      rd_state_q   <= rd_state_d;
      beats_left_q <= beats_left_d;
      out_data_q   <= out_data_d;
      out_keep_q   <= out_keep_d;
      out_user_q   <= out_user_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
    end
  end
endmodule

// File: tb/tb_rx_frame_buffer.sv
// Bench for rx_frame_buffer with a 64-word RAM, 2 frames in flight and a
// 220-byte frame limit, so overflow, in-flight limit and size limits are
// all reachable with short frames.
module tb_rx_frame_buffer;
  logic        aclk;
  logic        aresetn;
  logic [31:0] mac_s_tdata;
  logic [3:0]  mac_s_tkeep;
  logic        mac_s_tuser;
  logic        mac_s_tvalid;
  logic        mac_s_tlast;
  logic        mac_s_tready;
  logic [31:0] out_m_tdata;
  logic [3:0]  out_m_tkeep;
  logic [15:0] out_m_tuser;
  logic        out_m_tvalid;
  logic        out_m_tlast;
  logic        out_m_tready;
  logic [15:0] drop_count;
  logic [1:0]  dbg_wr_state;

  int checks = 0;
  int failures = 0;
  int exp_drops = 0;
  logic [52:0] exp_q[$];
  logic        hold_q = 1'b0;
  logic [52:0] hold_beat;

  typedef struct {
    int         nbytes;
    bit         err;
    bit         exp_pass;
    logic [1:0] exp_state;
  } frame_vec_t;

  rx_frame_buffer #(
    .DATA_DWORDS(64),
    .LEN_DEPTH(2),
    .MAX_FRAME_BYTES(220)
  ) dut (
    .aclk(aclk),
    .aresetn(aresetn),
    .mac_s_tdata(mac_s_tdata),
    .mac_s_tkeep(mac_s_tkeep),
    .mac_s_tuser(mac_s_tuser),
    .mac_s_tvalid(mac_s_tvalid),
    .mac_s_tlast(mac_s_tlast),
    .mac_s_tready(mac_s_tready),
    .out_m_tdata(out_m_tdata),
    .out_m_tkeep(out_m_tkeep),
    .out_m_tuser(out_m_tuser),
    .out_m_tvalid(out_m_tvalid),
    .out_m_tlast(out_m_tlast),
    .out_m_tready(out_m_tready),
    .drop_count(drop_count),
    .dbg_wr_state(dbg_wr_state)
  );

  // Clock and watchdog
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every output handshake must match the next expected beat,
  // and a stalled beat must hold all of its fields.
  always @(negedge aclk) begin
    if (!aresetn) begin
      hold_q = 1'b0;
    end else begin
      if (hold_q) begin
        check("hold_valid", 64'(out_m_tvalid), 64'd1);
        check("hold_beat", 64'({out_m_tdata, out_m_tkeep, out_m_tlast, out_m_tuser}), 64'(hold_beat));
      end
      if (out_m_tvalid && out_m_tready) begin
        hold_q = 1'b0;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat actual=%h required=none",
                   {out_m_tdata, out_m_tkeep, out_m_tlast, out_m_tuser});
        end else begin
          check("out_beat", 64'({out_m_tdata, out_m_tkeep, out_m_tlast, out_m_tuser}),
                64'(exp_q.pop_front()));
        end
      end else if (out_m_tvalid) begin
        hold_q    = 1'b1;
        hold_beat = {out_m_tdata, out_m_tkeep, out_m_tlast, out_m_tuser};
      end else begin
        hold_q = 1'b0;
      end
    end
  end

  // Driver: one frame, beats presented just after a rising edge.
  task automatic send_frame(input int nbytes, input bit err, input bit exp_pass,
                            output int stalls, output logic [1:0] st_at_last);
    int nbeats;
    int waited;
    bit acc;
    bit timed_out;
    logic [31:0] d;
    logic [3:0] k;
    nbeats = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    stalls = 0;
    st_at_last = 2'd3;
    timed_out = 1'b0;
    for (int b = 0; b < nbeats; b++) begin
      d = $urandom;
      k = 4'b1111;
      if (b == nbeats - 1) begin
        case (nbytes % 4)
          1: k = 4'b1000;
          2: k = 4'b1100;
          3: k = 4'b1110;
          default: k = 4'b1111;
        endcase
        if (nbytes == 0) k = 4'b0000;
      end
      if (exp_pass) exp_q.push_back({d, k, (b == nbeats - 1), 16'(nbytes)});
      mac_s_tdata  = d;
      mac_s_tkeep  = k;
      mac_s_tlast  = (b == nbeats - 1);
      mac_s_tuser  = err && (b == nbeats - 1);
      mac_s_tvalid = 1'b1;
      acc = 1'b0;
      waited = 0;
      while (!acc && !timed_out) begin
        @(negedge aclk);
        acc = mac_s_tready;
        if (acc && (b == nbeats - 1)) st_at_last = dbg_wr_state;
        @(posedge aclk);
        #1;
        if (!acc) begin
          stalls++;
          waited++;
          if (waited > 3000) timed_out = 1'b1;
        end
      end
      if (timed_out) break;
    end
    mac_s_tvalid = 1'b0;
    mac_s_tlast  = 1'b0;
    mac_s_tuser  = 1'b0;
    if (timed_out) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=stalled required=accepted nbytes=%0d", nbytes);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 3000) begin
      @(posedge aclk);
      #1;
      n++;
    end
    repeat (8) @(posedge aclk);
    #1;
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    frame_vec_t vecs[12];
    int stalls;
    logic [1:0] st;
    int n;

    vecs[0]  = '{64,  1'b0, 1'b1, 2'd0};
    vecs[1]  = '{61,  1'b0, 1'b1, 2'd0};
    vecs[2]  = '{60,  1'b0, 1'b1, 2'd0};
    vecs[3]  = '{100, 1'b1, 1'b0, 2'd0};
    vecs[4]  = '{60,  1'b0, 1'b1, 2'd0};
    vecs[5]  = '{0,   1'b0, 1'b0, 2'd0};
    vecs[6]  = '{220, 1'b0, 1'b1, 2'd0};
    vecs[7]  = '{221, 1'b0, 1'b0, 2'd0};
    vecs[8]  = '{300, 1'b0, 1'b0, 2'd1};
    vecs[9]  = '{4,   1'b0, 1'b1, 2'd0};
    vecs[10] = '{1,   1'b0, 1'b1, 2'd0};
    vecs[11] = '{7,   1'b0, 1'b1, 2'd0};

    // Reset
    aresetn = 1'b0;
    mac_s_tdata = '0;
    mac_s_tkeep = '0;
    mac_s_tuser = 1'b0;
    mac_s_tvalid = 1'b0;
    mac_s_tlast = 1'b0;
    out_m_tready = 1'b1;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_mac_tready", 64'(mac_s_tready), 64'd0);
    check("rst_out_tvalid", 64'(out_m_tvalid), 64'd0);
    check("rst_out_tlast", 64'(out_m_tlast), 64'd0);
    check("rst_out_tuser", 64'(out_m_tuser), 64'd0);
    check("rst_drop_count", 64'(drop_count), 64'd0);
    check("rst_wr_state", 64'(dbg_wr_state), 64'd0);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    check("run_mac_tready", 64'(mac_s_tready), 64'd1);

    // 64-byte frame: first output beat valid exactly 3 cycles after tlast
    send_frame(64, 1'b0, 1'b1, stalls, st);
    @(negedge aclk);
    check("latency_c1", 64'(out_m_tvalid), 64'd0);
    @(negedge aclk);
    check("latency_c2", 64'(out_m_tvalid), 64'd0);
    @(negedge aclk);
    check("latency_c3", 64'(out_m_tvalid), 64'd1);
    check("latency_tuser", 64'(out_m_tuser), 64'd64);
    wait_drain("lat_drain");
    check("lat_drops", 64'(drop_count), 64'd0);

    // Table of single frames, each drained before the next
    for (int i = 0; i < 12; i++) begin
      send_frame(vecs[i].nbytes, vecs[i].err, vecs[i].exp_pass, stalls, st);
      if (!vecs[i].exp_pass) exp_drops++;
      check($sformatf("vec%0d_stalls", i), 64'(stalls), 64'd0);
      check($sformatf("vec%0d_state_at_tlast", i), 64'(st), 64'(vecs[i].exp_state));
      wait_drain($sformatf("vec%0d_drain", i));
      check($sformatf("vec%0d_drops", i), 64'(drop_count), 64'(exp_drops));
      check($sformatf("vec%0d_state_idle", i), 64'(dbg_wr_state), 64'd0);
    end

    // Overflow: 200B buffered behind a stalled sink, 400B overflows and drops
    out_m_tready = 1'b0;
    send_frame(200, 1'b0, 1'b1, stalls, st);
    check("ovf_first_stalls", 64'(stalls), 64'd0);
    send_frame(400, 1'b0, 1'b0, stalls, st);
    exp_drops++;
    check("ovf_second_stalls", 64'(stalls), 64'd1);
    check("ovf_state_at_tlast", 64'(st), 64'd1);
    check("ovf_state_after", 64'(dbg_wr_state), 64'd0);
    check("ovf_drops", 64'(drop_count), 64'(exp_drops));
    check("ovf_queued", 64'(exp_q.size()), 64'd50);
    out_m_tready = 1'b1;
    wait_drain("ovf_drain");

    // In-flight limit: two committed frames block the third until drained
    out_m_tready = 1'b0;
    send_frame(16, 1'b0, 1'b1, stalls, st);
    send_frame(16, 1'b0, 1'b1, stalls, st);
    @(negedge aclk);
    check("lenfull_tready", 64'(mac_s_tready), 64'd0);
    @(posedge aclk);
    #1;
    fork
      send_frame(16, 1'b0, 1'b1, stalls, st);
      begin
        repeat (5) @(posedge aclk);
        #1;
        out_m_tready = 1'b1;
      end
    join
    check("lenfull_third_waited", 64'(stalls >= 5), 64'd1);
    wait_drain("lenfull_drain");
    check("lenfull_drops", 64'(drop_count), 64'(exp_drops));

    // Reset in the middle of a 64-byte frame on the output
    out_m_tready = 1'b0;
    send_frame(64, 1'b0, 1'b1, stalls, st);
    n = 0;
    while (!out_m_tvalid && n < 20) begin
      @(negedge aclk);
      n++;
    end
    check("rstmid_valid_seen", 64'(out_m_tvalid), 64'd1);
    @(posedge aclk);
    #1;
    out_m_tready = 1'b1;
    repeat (4) @(posedge aclk);
    #1;
    aresetn = 1'b0;
    out_m_tready = 1'b0;
    #1;
    check("rstmid_tvalid", 64'(out_m_tvalid), 64'd0);
    check("rstmid_tlast", 64'(out_m_tlast), 64'd0);
    check("rstmid_tuser", 64'(out_m_tuser), 64'd0);
    check("rstmid_drops", 64'(drop_count), 64'd0);
    check("rstmid_left", 64'(exp_q.size()), 64'd12);
    exp_q.delete();
    exp_drops = 0;
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
    @(posedge aclk);
    #1;
    out_m_tready = 1'b1;
    send_frame(32, 1'b0, 1'b1, stalls, st);
    wait_drain("rstmid_drain");
    check("rstmid_final_drops", 64'(drop_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
